// File: rtl/m_cg_pkg.sv
// Shared definitions for the idle-timeout clock-gating controller:
// FSM state encoding and default widths used by the gate controller.
package m_cg_pkg;

    // Default number of requesters sharing one gated clock branch.
    localparam int N_REQ_DEF = 4;

    // Default width of the wake/idle countdown counter.
    localparam int CNT_W_DEF = 8;

    // FSM state encoding, also visible on the state_o port.
    typedef logic [1:0] cg_state_t;

    localparam logic [1:0] ST_OFF  = 2'd0;
    localparam logic [1:0] ST_WAKE = 2'd1;
    localparam logic [1:0] ST_ON   = 2'd2;
    localparam logic [1:0] ST_IDLE = 2'd3;

endpackage : m_cg_pkg

// File: rtl/m_or.sv
// Standard-cell wrapper for a two-input OR used as a clock gate.
// The technology libraries map this wrapper onto their own OR cell;
// the body here is the generic simulation model.
module m_or (
    input  logic A,
    input  logic B,
    output logic Z
);

    // Clock passes through while B is low; B high parks the output high.
    assign Z = A | B;

endmodule : m_or

// File: rtl/m_clk_gate_ctrl.sv
// Idle-timeout clock-gating controller. Several requesters share one gated
// clock branch through a four-phase req/ack handshake. The controller
// sequences wake-up latency, idle hysteresis and shutdown, and drives an
// OR-type clock gate: gclk = clk | gate_force. Because gate_force only
// changes on rising clk (while clk is high) the gated clock is glitch free.
module m_clk_gate_ctrl
    import m_cg_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int WAKE_CYC = 2,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] ack,
    input  logic             force_on,
    input  logic [CNT_W-1:0] idle_timeout,
    output logic             gclk,
    output logic             clk_on,
    output logic [1:0]       state_o
);

    // Value loaded into the counter when leaving OFF; WAKE then counts it down
    // to zero before entering ON.
    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    cg_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gateForce_q, gateForce_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             anyReq;

    // A debug force counts as a request so it both wakes and holds the clock.
    assign anyReq = (|req) | force_on;

    // Next-state, counter, gate and ack decisions for the gating FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gateForce_d = gateForce_q;
        ack_d       = '0;
        case (state_q)
            ST_OFF: begin
                if (anyReq) begin
                    state_d     = ST_WAKE;
                    gateForce_d = 1'b0;
                    cnt_d       = WAKE_LOAD;
                end
            end
            ST_WAKE: begin
                // Wake always runs to completion; no ack until ON is reached.
                if (cnt_q == '0) begin
                    state_d = ST_ON;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_ON: begin
                if (anyReq) begin
                    ack_d = req;
                end else if (idle_timeout == '0) begin
                    state_d     = ST_OFF;
                    gateForce_d = 1'b1;
                    cnt_d       = '0;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = idle_timeout;
                end
            end
            ST_IDLE: begin
                // A new request wins over an expiring countdown; clock never stopped.
                if (anyReq) begin
                    state_d = ST_ON;
                    ack_d   = req;
                end else if (cnt_q <= CNT_ONE) begin
                    state_d     = ST_OFF;
                    gateForce_d = 1'b1;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d     = ST_OFF;
                gateForce_d = 1'b1;
                cnt_d       = '0;
            end
        endcase
    end

    // State, counter, gate control and acks all register on rising clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_OFF;
            cnt_q       <= '0;
            gateForce_q <= 1'b1;
            ack_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gateForce_q <= gateForce_d;
            ack_q       <= ack_d;
        end
    end

    // The gate itself stays a direct instance of the std-cell OR wrapper.
    m_or uGate (
        .A (clk),
        .B (gateForce_q),
        .Z (gclk)
    );

    assign ack     = ack_q;
    assign clk_on  = ~gateForce_q;
    assign state_o = state_q;

    // Per-requester handshake checks: acks track req, and req may only
    // drop once its ack is already high.
    for (genvar i = 0; i < N_REQ; i++) begin : gHandshake
        assert property (@(posedge clk) disable iff (!rst_n)
            ack_q[i] |-> $past(req[i]));
        assert property (@(posedge clk) disable iff (!rst_n)
            $fell(req[i]) |-> ack_q[i]);
    end

    // The gated clock must be running whenever any grant is outstanding.
    assert property (@(posedge clk) disable iff (!rst_n)
        (|ack_q) |-> !gateForce_q);

endmodule : m_clk_gate_ctrl

// File: tb/tb_m_clk_gate_ctrl.sv
// Self-checking bench for m_clk_gate_ctrl: a table of per-edge vectors is
// driven through a scoreboard queue, followed by a reset-during-wake sequence.
module tb_m_clk_gate_ctrl;
    import m_cg_pkg::*;

    localparam int N  = 4;
    localparam int WK = 2;
    localparam int CW = 8;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [N-1:0]  ack;
    logic          forceOn;
    logic [CW-1:0] idleTimeout;
    logic          gclk;
    logic          clkOn;
    logic [1:0]    stateO;

    typedef struct packed {
        logic [N-1:0]  reqV;
        logic          forceV;
        logic [CW-1:0] idleV;
        logic [1:0]    expState;
        logic [N-1:0]  expAck;
        logic          expClkOn;
    } vec_t;

    vec_t vecTable[$];
    vec_t expQ[$];
    vec_t lastExp;
    int   errors = 0;
    int   checks = 0;
    int   vecIdx = -1;

    m_clk_gate_ctrl #(
        .N_REQ    (N),
        .WAKE_CYC (WK),
        .CNT_W    (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .ack          (ack),
        .force_on     (forceOn),
        .idle_timeout (idleTimeout),
        .gclk         (gclk),
        .clk_on       (clkOn),
        .state_o      (stateO)
    );

    // Free-running source clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mkVec(input logic [N-1:0] r, input logic f,
                                   input logic [CW-1:0] it, input logic [1:0] st,
                                   input logic [N-1:0] a, input logic co);
        vec_t v;
        v.reqV     = r;
        v.forceV   = f;
        v.idleV    = it;
        v.expState = st;
        v.expAck   = a;
        v.expClkOn = co;
        return v;
    endfunction

    task automatic checkVal(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s (vector %0d): got %0h, expected %0h", name, vecIdx, got, exp);
        end
    endtask

    // Pops the expected record for the edge just taken and compares outputs.
    task automatic checkOutput();
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_empty (vector %0d): got no entry, expected one", vecIdx);
        end else begin
            lastExp = expQ.pop_front();
            checkVal("state_o", int'(stateO), int'(lastExp.expState));
            checkVal("ack", int'(ack), int'(lastExp.expAck));
            checkVal("clk_on", int'(clkOn), int'(lastExp.expClkOn));
        end
    endtask

    // Drives one vector before a rising edge, then checks after the edge and
    // checks the gated clock during the following low phase of clk.
    task automatic applyStimulus(input vec_t v);
        req         = v.reqV;
        forceOn     = v.forceV;
        idleTimeout = v.idleV;
        expQ.push_back(v);
        @(posedge clk);
        #1;
        checkOutput();
        @(negedge clk);
        #1;
        checkVal("gclk_low_phase", int'(gclk), int'(!lastExp.expClkOn));
    endtask

    initial begin
        rst_n       = 1'b0;
        req         = '0;
        forceOn     = 1'b0;
        idleTimeout = 8'd5;

        // Reset then idle: twenty edges with nothing requested.
        for (int i = 0; i < 20; i++) vecTable.push_back(mkVec(4'b0000, 1'b0, 8'd5, ST_OFF, 4'b0000, 1'b0));
        // Wake latency: ack appears WAKE_CYC+1 edges after req is sampled.
        vecTable.push_back(mkVec(4'b0001, 1'b0, 8'd5, ST_WAKE, 4'b0000, 1'b1));
        vecTable.push_back(mkVec(4'b0001, 1'b0, 8'd5, ST_WAKE, 4'b0000, 1'b1));
        vecTable.push_back(mkVec(4'b0001, 1'b0, 8'd5, ST_ON,   4'b0000, 1'b1));
        vecTable.push_back(mkVec(4'b0001, 1'b0, 8'd5, ST_ON,   4'b0001, 1'b1));
        // Idle timeout of 5: five IDLE edges, then OFF.
        for (int i = 0; i < 5; i++) vecTable.push_back(mkVec(4'b0000, 1'b0, 8'd5, ST_IDLE, 4'b0000, 1'b1));
        vecTable.push_back(mkVec(4'b0000, 1'b0, 8'd5, ST_OFF, 4'b0000, 1'b0));
        vecTable.push_back(mkVec(4'b0000, 1'b0, 8'd5, ST_OFF, 4'b0000, 1'b0));
        // Re-request during IDLE with timeout 10.
        vecTable.push_back(mkVec(4'b0010, 1'b0, 8'd10, ST_WAKE, 4'b0000, 1'b1));
        vecTable.push_back(mkVec(4'b0010, 1'b0, 8'd10, ST_WAKE, 4'b0000, 1'b1));
        vecTable.push_back(mkVec(4'b0010, 1'b0, 8'd10, ST_ON,   4'b0000, 1'b1));
        vecTable.push_back(mkVec(4'b0010, 1'b0, 8'd10, ST_ON,   4'b0010, 1'b1));
        for (int i = 0; i < 4; i++) vecTable.push_back(mkVec(4'b0000, 1'b0, 8'd10, ST_IDLE, 4'b0000, 1'b1));
        vecTable.push_back(mkVec(4'b0010, 1'b0, 8'd10, ST_ON, 4'b0010, 1'b1));
        // Overlapping requesters, then force_on, then force drop with timeout 0.
        vecTable.push_back(mkVec(4'b0101, 1'b0, 8'd10, ST_ON, 4'b0101, 1'b1));
        vecTable.push_back(mkVec(4'b0100, 1'b0, 8'd10, ST_ON, 4'b0100, 1'b1));
        vecTable.push_back(mkVec(4'b0100, 1'b0, 8'd10, ST_ON, 4'b0100, 1'b1));
        for (int i = 0; i < 6; i++) vecTable.push_back(mkVec(4'b0000, 1'b1, 8'd10, ST_ON, 4'b0000, 1'b1));
        vecTable.push_back(mkVec(4'b0000, 1'b0, 8'd0, ST_OFF, 4'b0000, 1'b0));
        vecTable.push_back(mkVec(4'b0000, 1'b0, 8'd0, ST_OFF, 4'b0000, 1'b0));
        // Request arriving on the edge where IDLE would expire wins.
        vecTable.push_back(mkVec(4'b0001, 1'b0, 8'd2, ST_WAKE, 4'b0000, 1'b1));
        vecTable.push_back(mkVec(4'b0001, 1'b0, 8'd2, ST_WAKE, 4'b0000, 1'b1));
        vecTable.push_back(mkVec(4'b0001, 1'b0, 8'd2, ST_ON,   4'b0000, 1'b1));
        vecTable.push_back(mkVec(4'b0001, 1'b0, 8'd2, ST_ON,   4'b0001, 1'b1));
        vecTable.push_back(mkVec(4'b0000, 1'b0, 8'd2, ST_IDLE, 4'b0000, 1'b1));
        vecTable.push_back(mkVec(4'b0000, 1'b0, 8'd2, ST_IDLE, 4'b0000, 1'b1));
        vecTable.push_back(mkVec(4'b0001, 1'b0, 8'd2, ST_ON,   4'b0001, 1'b1));
        // Expiry into OFF, then a request right after starts a full WAKE.
        vecTable.push_back(mkVec(4'b0000, 1'b0, 8'd2, ST_IDLE, 4'b0000, 1'b1));
        vecTable.push_back(mkVec(4'b0000, 1'b0, 8'd2, ST_IDLE, 4'b0000, 1'b1));
        vecTable.push_back(mkVec(4'b0000, 1'b0, 8'd2, ST_OFF,  4'b0000, 1'b0));
        vecTable.push_back(mkVec(4'b1000, 1'b0, 8'd2, ST_WAKE, 4'b0000, 1'b1));
        vecTable.push_back(mkVec(4'b1000, 1'b0, 8'd2, ST_WAKE, 4'b0000, 1'b1));
        vecTable.push_back(mkVec(4'b1000, 1'b0, 8'd2, ST_ON,   4'b0000, 1'b1));
        vecTable.push_back(mkVec(4'b1000, 1'b0, 8'd2, ST_ON,   4'b1000, 1'b1));
        vecTable.push_back(mkVec(4'b0000, 1'b0, 8'd2, ST_IDLE, 4'b0000, 1'b1));
        vecTable.push_back(mkVec(4'b0000, 1'b0, 8'd2, ST_IDLE, 4'b0000, 1'b1));
        vecTable.push_back(mkVec(4'b0000, 1'b0, 8'd2, ST_OFF,  4'b0000, 1'b0));

        // Reset held for three cycles; outputs checked during clk low phase.
        repeat (3) @(negedge clk);
        #1;
        checkVal("reset_state", int'(stateO), int'(ST_OFF));
        checkVal("reset_ack", int'(ack), 0);
        checkVal("reset_clk_on", int'(clkOn), 0);
        checkVal("reset_gclk", int'(gclk), 1);
        rst_n = 1'b1;

        foreach (vecTable[i]) begin
            vecIdx = i;
            applyStimulus(vecTable[i]);
        end

        // Reset asserted one cycle into WAKE acts immediately.
        vecIdx = 1000;
        applyStimulus(mkVec(4'b0001, 1'b0, 8'd5, ST_WAKE, 4'b0000, 1'b1));
        rst_n = 1'b0;
        #1;
        checkVal("midwake_reset_state", int'(stateO), int'(ST_OFF));
        checkVal("midwake_reset_clk_on", int'(clkOn), 0);
        checkVal("midwake_reset_gclk", int'(gclk), 1);
        checkVal("midwake_reset_ack", int'(ack), 0);
        @(posedge clk);
        #1;
        checkVal("midwake_held_state", int'(stateO), int'(ST_OFF));
        @(negedge clk);
        #1;
        checkVal("midwake_held_gclk", int'(gclk), 1);
        rst_n = 1'b1;

        // Recovery follows the normal wake timing.
        vecIdx = 1001;
        applyStimulus(mkVec(4'b0001, 1'b0, 8'd5, ST_WAKE, 4'b0000, 1'b1));
        vecIdx = 1002;
        applyStimulus(mkVec(4'b0001, 1'b0, 8'd5, ST_WAKE, 4'b0000, 1'b1));
        vecIdx = 1003;
        applyStimulus(mkVec(4'b0001, 1'b0, 8'd5, ST_ON, 4'b0000, 1'b1));
        vecIdx = 1004;
        applyStimulus(mkVec(4'b0001, 1'b0, 8'd5, ST_ON, 4'b0001, 1'b1));
        vecIdx = 1005;
        applyStimulus(mkVec(4'b0000, 1'b0, 8'd5, ST_IDLE, 4'b0000, 1'b1));

        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_leftover: got %0d entries, expected 0", expQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_m_clk_gate_ctrl
